// File: rtl/ip_uart_rx_if.sv
// Byte-side handshake of ip_uart_rx: the hold register (data/valid), the consumer
// ack, and the framing-error / overrun status pulses.
interface ip_uart_rx_if;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ack;
    logic       recv_error;
    logic       recv_overrun;

    modport master (output recv_data, recv_valid, recv_error, recv_overrun, input recv_ack);
    modport slave  (input recv_data, recv_valid, recv_error, recv_overrun, output recv_ack);
endinterface

// File: rtl/ip_uart_rx.sv
// 8N1 UART receiver: synchronized line, 3-sample majority vote per bit, and a
// one-byte hold register with level valid/ack plus error/overrun pulses.
module ip_uart_rx #(
    parameter int clk_freq  = 75000000,
    parameter int uart_freq = 115200
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         uart_rx,
    ip_uart_rx_if.master recv
);
    localparam int BIT_CYCLES = clk_freq / uart_freq;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LO  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(HALF);
    localparam logic [CW-1:0] CNT_HI  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_END = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          rx_meta, rx_s, rx_d;
    logic          smp_lo, smp_mid, maj;
    logic          deliver, frame_err;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // The third vote is the live rx_s, so the bit is decided on the CNT_HI cycle itself.
    assign maj = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            smp_lo  <= 1'b1;
            smp_mid <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            if (cnt == CNT_LO)  smp_lo  <= rx_s;
            if (cnt == CNT_MID) smp_mid <= rx_s;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        deliver   = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s && rx_d) state_nxt = START;
            end
            START: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_HI && maj) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_END) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_HI) shreg_nxt = {maj, shreg[7:1]};
                if (cnt == CNT_END) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 1'b1;
                    if (idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                cnt_nxt = cnt + 1'b1;
                // Leave mid stop bit so a slightly fast sender's next start edge is not missed.
                if (cnt == CNT_HI) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    deliver   = maj;
                    frame_err = ~maj;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            recv.recv_data    <= 8'h00;
            recv.recv_valid   <= 1'b0;
            recv.recv_error   <= 1'b0;
            recv.recv_overrun <= 1'b0;
        end else begin
            recv.recv_error   <= frame_err;
            recv.recv_overrun <= 1'b0;
            if (deliver) begin
                // A same-cycle ack frees the slot, so the new byte takes it.
                if (!recv.recv_valid || recv.recv_ack) begin
                    recv.recv_data  <= shreg;
                    recv.recv_valid <= 1'b1;
                end else begin
                    recv.recv_overrun <= 1'b1;
                end
            end else if (recv.recv_ack) begin
                recv.recv_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ip_uart_rx.md
# ip_uart_rx

UART receiver that pairs with the existing `ip_uart` transmitter. It takes the asynchronous serial line (8N1, LSB first, idle high) and converts it to bytes in the `clk` domain. Each byte is delivered through a level valid/ack handshake with a one-byte hold register, and framing errors and overruns are reported as pulses. It sits next to `ip_uart` in cartridge tops so a host PC can send commands to test engines such as the PSRAM tester.

## Interface
Parameters:
- `clk_freq`, 75000000: `clk` frequency in Hz.
- `uart_freq`, 115200: baud rate in Hz.
- Derived: `BIT_CYCLES = clk_freq / uart_freq` (integer, truncated) and `HALF = BIT_CYCLES / 2`.
- Constraint: `BIT_CYCLES >= 8`. Counter width is `$clog2(BIT_CYCLES)`.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial input, asynchronous to `clk`, idle high.
- `recv_data`  out  8  last received byte; holds its value while `recv_valid`=1.
- `recv_valid`  out  1  level; a byte is available.
- `recv_ack`  in  1  one-cycle pulse from the consumer; clears `recv_valid`.
- `recv_error`  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
- `recv_overrun`  out  1  one-cycle pulse when a byte completes while the hold register is still full.

## Operation
- Input sync: two-flop synchronizer on `uart_rx`, reset value 1, giving `rx_s`. A third flop `rx_d` is used for falling-edge detection.
- Majority sample: within each bit, `rx_s` is captured at counts `HALF-1`, `HALF` and `HALF+1`. The bit value is the 2-of-3 majority, decided at count `HALF+1`.
- FSM states: IDLE, START, DATA, STOP. The reset state is IDLE.
  - IDLE: bit counter = 0. When `rx_s`=0 and `rx_d`=1, go to START with count = 0. A line that is held low with no falling edge never starts a frame.
  - START: count increments every cycle. At `HALF+1`, a majority of 1 is a glitch: go to IDLE, with no pulse and no data change. At `BIT_CYCLES-1`, go to DATA with count = 0 and bit index = 0.
  - DATA: at `HALF+1`, shift the majority bit into the MSB of the shift register (right shift, so the byte lands LSB first). At `BIT_CYCLES-1`, count = 0 and index++. After index 7 completes, go to STOP.
  - STOP: at `HALF+1`, evaluate the stop bit and go straight to IDLE. This early return gives half a bit of tolerance for baud mismatch.
    - Majority 1: deliver the byte.
    - Majority 0: pulse `recv_error` and discard the byte. After a break, IDLE waits for the line to return high and then fall again.
- Delivery, in the cycle after the STOP decision:
  - If `recv_valid`=0, or `recv_ack`=1 in the same cycle: load `recv_data` and set `recv_valid`=1.
  - Otherwise: keep the old byte, drop the new one, and pulse `recv_overrun`.
- Ack: `recv_ack` with `recv_valid`=1 clears `recv_valid` on the next edge, unless a delivery happens in the same cycle (delivery wins, and the new data is shown). `recv_ack` while `recv_valid`=0 is ignored.
- Reset, asserted at any time including mid-frame: immediate return to IDLE. The partial byte is lost.

## Timing
- Reset values of outputs:
  - `recv_data` = 8'h00.
  - `recv_valid` = 0.
  - `recv_error` = 0.
  - `recv_overrun` = 0.
- Internal reset values: shift register 0, counters 0, `rx_s`/`rx_d` = 1.
- Latency: `recv_valid` rises 2 + 9*`BIT_CYCLES` + `HALF` + 3 cycles after the falling `uart_rx` edge (nominal). The bench tolerance is ±2 cycles.
- `recv_error` and `recv_overrun` fire on the same cycle that `recv_valid` would have risen. Each is high for exactly 1 cycle.
- Back-to-back frames need no idle gap. A start edge is detected from the cycle after the STOP decision onward.
- Throughput: one byte per 10 bit times. The consumer must ack within about 10 bit times to avoid overrun.

## Test plan
Fast benches use `clk_freq`=1000000 and `uart_freq`=100000 (`BIT_CYCLES`=10, `HALF`=5). One bench runs at the defaults (651 / 325).
- Single byte: send 8'hA5 at an exact baud rate → `recv_valid`=1, `recv_data`=8'hA5 at the nominal latency ±2. Ack → `recv_valid`=0 the next cycle. No error or overrun pulse.
- Glitch rejection: a 2-cycle low pulse on an idle line → stay IDLE, no outputs change. A single-cycle 1 in the middle of data bit 3 of byte 8'h00 → `recv_data`=8'h00 (majority vote).
- Framing error: send 8'h3C with stop bit = 0, then the line returns high → one `recv_error` pulse and `recv_valid` stays 0. A following good 8'h55 → `recv_data`=8'h55.
- Overrun and simultaneous ack:
  - Send 8'h11 then 8'h22 back-to-back with no ack → `recv_data`=8'h11 is retained and one `recv_overrun` pulse occurs.
  - Repeat with `recv_ack` asserted on the exact delivery cycle of 8'h22 → `recv_data`=8'h22, `recv_valid` stays 1, no overrun.
- Baud tolerance: stream 8'h00, 8'hFF, 8'h81 at ±3% bit-period skew → all three received correctly with no errors.
- Reset mid-frame: assert `n_reset` during data bit 4, release, then send 8'hC3 → only 8'hC3 is delivered. All outputs are at their reset values during reset.
